// File: rtl/riscv_mem_pkg.sv
// ----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared types and constants for the CPU-side memory port arbiter.
//   XLEN        : data width of the memory interface
//   OWNER_IF/D  : encoding of which requester owns an in-flight access
//   resp_tag_t  : response pipeline tag, bit layout {valid, owner, is_store}
//   grant_sel_e : which requester (if any) is issued to memory this cycle
//   make_tag    : builds the response tag for the access issued this cycle
// ----------------------------------------------------------------------------
package riscv_mem_pkg;

  localparam int XLEN = 32;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic is_store;
  } resp_tag_t;

  localparam resp_tag_t TAG_IDLE = '{valid: 1'b0, owner: 1'b0, is_store: 1'b0};

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_D    = 2'd2
  } grant_sel_e;

  // Tag for the access issued this cycle; only stores from the data port
  // are flagged so the response stage can return zero instead of memory data.
  function automatic resp_tag_t make_tag(input grant_sel_e sel, input logic we);
    resp_tag_t tag;
    tag = TAG_IDLE;
    case (sel)
      SEL_IF:  tag = '{valid: 1'b1, owner: OWNER_IF, is_store: 1'b0};
      SEL_D:   tag = '{valid: 1'b1, owner: OWNER_D,  is_store: we};
      default: tag = TAG_IDLE;
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// ----------------------------------------------------------------------------
// arb_starve_counter
// Saturating count of consecutive cycles the fetch port was denied.
//   clk      in  clock
//   reset    in  synchronous active-high reset (count -> 0)
//   inc      in  fetch requested but not granted this cycle
//   clr      in  fetch granted or not requesting; clear has priority over inc
//   at_limit out count has reached LIMIT (fetch must win next contention)
// ----------------------------------------------------------------------------
module arb_starve_counter
  import riscv_mem_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: clear wins, otherwise increment until saturated at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory (1-cycle read latency) between the
// instruction-fetch port (if_*) and the load/store port (d_*). At most one
// access is issued per cycle; responses return two cycles after the grant, in
// grant order, through a 2-deep tag pipeline.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   if_req/if_addr                fetch request (held until if_gnt)
//   if_gnt                        fetch issued this cycle (combinational)
//   if_rvalid/if_rdata            fetch response (pulse, registered data)
//   d_req/d_we/d_be/d_addr/d_wdata data request (held until d_gnt)
//   d_gnt                         data access issued this cycle (combinational)
//   d_rvalid/d_rdata              load data / store ack (rdata 0 for stores)
//   mem_en/we/be/addr/wdata       memory request driven from the winner
//   mem_rdata                     memory read data, one cycle after a read
// Parameters: AW address width, RR_MODE (0 data-first with starvation guard,
//   1 round-robin), STARVE_LIMIT denied-fetch cycles before fetch is forced.
// ----------------------------------------------------------------------------
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW           = 32,
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  grant_sel_e      sel_s;
  logic            at_limit_s;
  logic            starve_inc_s;
  logic            starve_clr_s;

  logic            last_owner_q, last_owner_d;
  resp_tag_t       tag_s1_q, tag_s1_d;
  resp_tag_t       tag_s2_q, tag_s2_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;

  // Arbitration: pick at most one requester; nothing is issued during reset.
  always_comb begin
    sel_s = SEL_NONE;
    if (reset) begin
      sel_s = SEL_NONE;
    end else if (if_req && d_req) begin
      if (RR_MODE != 0) begin
        // Round-robin: the port that did not win last time goes first.
        if (last_owner_q == OWNER_IF) begin
          sel_s = SEL_D;
        end else begin
          sel_s = SEL_IF;
        end
      end else begin
        // Data-first, but a fetch denied STARVE_LIMIT cycles in a row wins.
        if (at_limit_s) begin
          sel_s = SEL_IF;
        end else begin
          sel_s = SEL_D;
        end
      end
    end else if (if_req) begin
      sel_s = SEL_IF;
    end else if (d_req) begin
      sel_s = SEL_D;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Grants and memory request, driven from the winner's inputs.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {XLEN{1'b0}};
    case (sel_s)
      SEL_IF: begin
        if_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_be   = 4'hF;
        mem_addr = if_addr;
      end
      SEL_D: begin
        d_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_we ? d_wdata : {XLEN{1'b0}};
      end
      default: begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
      end
    endcase
  end

  assign starve_inc_s = if_req & ~if_gnt;
  assign starve_clr_s = ~if_req | if_gnt;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (starve_inc_s),
    .clr      (starve_clr_s),
    .at_limit (at_limit_s)
  );

  // Next state: owner history, tag pipe and per-port read data capture.
  always_comb begin
    last_owner_d = last_owner_q;
    case (sel_s)
      SEL_IF:  last_owner_d = OWNER_IF;
      SEL_D:   last_owner_d = OWNER_D;
      default: last_owner_d = last_owner_q;
    endcase

    tag_s1_d = make_tag(sel_s, d_we);
    tag_s2_d = tag_s1_q;

    // Memory data belongs to the stage-1 access; only its owner's register
    // updates, so the other port's rdata keeps its last value.
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (tag_s1_q.valid) begin
      if (tag_s1_q.owner == OWNER_IF) begin
        if_rdata_d = mem_rdata;
      end else if (tag_s1_q.is_store) begin
        d_rdata_d = {XLEN{1'b0}};
      end else begin
        d_rdata_d = mem_rdata;
      end
    end else begin
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
    end
  end

  // State registers; reset discards any in-flight responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q <= OWNER_IF;
      tag_s1_q     <= TAG_IDLE;
      tag_s2_q     <= TAG_IDLE;
      if_rdata_q   <= {XLEN{1'b0}};
      d_rdata_q    <= {XLEN{1'b0}};
    end else begin
      last_owner_q <= last_owner_d;
      tag_s1_q     <= tag_s1_d;
      tag_s2_q     <= tag_s2_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_rvalid = tag_s2_q.valid && (tag_s2_q.owner == OWNER_IF);
  assign d_rvalid  = tag_s2_q.valid && (tag_s2_q.owner == OWNER_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiters (data-first and round-robin) share one stimulus stream, each
// with its own memory read port onto a common memory model. Expected responses
// are queued when an access is issued; a monitor pops and compares them when
// the selected DUT raises rvalid.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic        d0_if_gnt, d0_if_rvalid, d0_d_gnt, d0_d_rvalid;
  logic [31:0] d0_if_rdata, d0_d_rdata;
  logic        d0_mem_en, d0_mem_we;
  logic [3:0]  d0_mem_be;
  logic [31:0] d0_mem_addr, d0_mem_wdata;
  logic [31:0] mem_rdata0;

  logic        d1_if_gnt, d1_if_rvalid, d1_d_gnt, d1_d_rvalid;
  logic [31:0] d1_if_rdata, d1_d_rdata;
  logic        d1_mem_en, d1_mem_we;
  logic [3:0]  d1_mem_be;
  logic [31:0] d1_mem_addr, d1_mem_wdata;
  logic [31:0] mem_rdata1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic active = 1'b0;   // 0: monitor dut0 (RR_MODE=0), 1: dut1 (RR_MODE=1)

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_if[$];
  exp_t exp_d[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.AW(32), .RR_MODE(0), .STARVE_LIMIT(4)) u_dut0 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(d0_if_gnt),
    .if_rvalid(d0_if_rvalid), .if_rdata(d0_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d0_d_gnt), .d_rvalid(d0_d_rvalid), .d_rdata(d0_d_rdata),
    .mem_en(d0_mem_en), .mem_we(d0_mem_we), .mem_be(d0_mem_be),
    .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata), .mem_rdata(mem_rdata0)
  );

  mem_port_arbiter #(.AW(32), .RR_MODE(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(d1_if_gnt),
    .if_rvalid(d1_if_rvalid), .if_rdata(d1_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d1_d_gnt), .d_rvalid(d1_d_rvalid), .d_rdata(d1_d_rdata),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_be(d1_mem_be),
    .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata), .mem_rdata(mem_rdata1)
  );

  // Memory model: preloaded words plus a written-word overlay.
  logic [31:0] wmem   [0:255];
  logic        wvalid [0:255];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0000_0013;
      32'h0000_0020: return 32'h1111_1111;
      32'h0000_0040: return 32'h2222_2222;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (wvalid[a[9:2]] === 1'b1) return wmem[a[9:2]];
    else return init_val(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (d0_mem_en && !d0_mem_we) mem_rdata0 <= rd(d0_mem_addr);
    if (d1_mem_en && !d1_mem_we) mem_rdata1 <= rd(d1_mem_addr);
    if (d0_mem_en && d0_mem_we) begin
      wmem[d0_mem_addr[9:2]]   <= merge(rd(d0_mem_addr), d0_mem_wdata, d0_mem_be);
      wvalid[d0_mem_addr[9:2]] <= 1'b1;
    end
  end

  // Monitored response signals of the selected DUT.
  logic        m_if_rvalid, m_d_rvalid;
  logic [31:0] m_if_rdata, m_d_rdata;
  assign m_if_rvalid = active ? d1_if_rvalid : d0_if_rvalid;
  assign m_if_rdata  = active ? d1_if_rdata  : d0_if_rdata;
  assign m_d_rvalid  = active ? d1_d_rvalid  : d0_d_rvalid;
  assign m_d_rdata   = active ? d1_d_rdata   : d0_d_rdata;

  // Scoreboard monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (m_if_rvalid) begin
      n_checks++;
      if (exp_if.size() == 0) begin
        n_fail++;
        $display("FAIL if_resp_unexpected: got if_rvalid=1 at cycle %0d, required none", cyc);
      end else begin
        e = exp_if.pop_front();
        if (m_if_rdata !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL if_resp: got data %h at cycle %0d, required %h at cycle %0d",
                   m_if_rdata, cyc, e.data, e.cyc);
        end
      end
    end
    if (m_d_rvalid) begin
      n_checks++;
      if (exp_d.size() == 0) begin
        n_fail++;
        $display("FAIL d_resp_unexpected: got d_rvalid=1 at cycle %0d, required none", cyc);
      end else begin
        e = exp_d.pop_front();
        if (m_d_rdata !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL d_resp: got data %h at cycle %0d, required %h at cycle %0d",
                   m_d_rdata, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_if(input logic [31:0] data, input int at);
    exp_t e;
    e.data = data;
    e.cyc  = at;
    exp_if.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] data, input int at);
    exp_t e;
    e.data = data;
    e.cyc  = at;
    exp_d.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [5:0] pat3;
    pat3 = 6'b101111;   // bit k = expected d_gnt in contention cycle k (RR_MODE=0)

    // 1: reset held with both requesting
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h10;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_be    = 4'hF;
    d_addr  = 32'h40;
    d_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_if_gnt",    {31'd0, d0_if_gnt},    32'd0);
      check("rst_d_gnt",     {31'd0, d0_d_gnt},     32'd0);
      check("rst_mem_en",    {31'd0, d0_mem_en},    32'd0);
      check("rst_if_rvalid", {31'd0, d0_if_rvalid}, 32'd0);
      check("rst_d_rvalid",  {31'd0, d0_d_rvalid},  32'd0);
      check("rst_if_rdata",  d0_if_rdata,           32'h0);
      check("rst_d_rdata",   d0_d_rdata,            32'h0);
    end

    // 2: lone fetch from 0x10
    step();
    reset  = 1'b0;
    d_req  = 1'b0;
    if_req = 1'b1;
    @(negedge clk);
    check("t2_if_gnt",   {31'd0, d0_if_gnt}, 32'd1);
    check("t2_d_gnt",    {31'd0, d0_d_gnt},  32'd0);
    check("t2_mem_en",   {31'd0, d0_mem_en}, 32'd1);
    check("t2_mem_we",   {31'd0, d0_mem_we}, 32'd0);
    check("t2_mem_addr", d0_mem_addr,        32'h10);
    push_if(32'h0000_0013, cyc + 2);
    step();
    idle(4);
    @(negedge clk);
    check("t2_idle_mem_en", {31'd0, d0_mem_en}, 32'd0);

    // 3: data-first contention with starvation guard
    step();
    if_req  = 1'b1;
    if_addr = 32'h20;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h40;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t3_d_gnt",  {31'd0, d0_d_gnt},  {31'd0, pat3[k]});
      check("t3_if_gnt", {31'd0, d0_if_gnt}, {31'd0, ~pat3[k]});
      if (k == 4) check("t3_starve_at_limit", {28'd0, u_dut0.u_starve.cnt_q}, 32'd4);
      if (k == 5) check("t3_starve_cleared",  {28'd0, u_dut0.u_starve.cnt_q}, 32'd0);
      if (pat3[k]) push_d(32'h2222_2222, cyc + 2);
      else         push_if(32'h1111_1111, cyc + 2);
      step();
    end
    idle(4);

    // 4: store then load to 0x100
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'b0011;
    d_addr  = 32'h100;
    d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t4_st_d_gnt",     {31'd0, d0_d_gnt},  32'd1);
    check("t4_st_mem_we",    {31'd0, d0_mem_we}, 32'd1);
    check("t4_st_mem_be",    {28'd0, d0_mem_be}, 32'h3);
    check("t4_st_mem_addr",  d0_mem_addr,        32'h100);
    check("t4_st_mem_wdata", d0_mem_wdata,       32'hDEAD_BEEF);
    push_d(32'h0, cyc + 2);
    step();
    d_we = 1'b0;
    d_be = 4'hF;
    @(negedge clk);
    check("t4_ld_d_gnt",  {31'd0, d0_d_gnt},  32'd1);
    check("t4_ld_mem_we", {31'd0, d0_mem_we}, 32'd0);
    push_d(32'h0000_BEEF, cyc + 2);
    step();
    idle(4);

    // 5: round-robin alternation on dut1 (last owner so far is data)
    active  = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h10;
    d_req   = 1'b1;
    d_addr  = 32'h40;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_rr_if_gnt", {31'd0, d1_if_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("t5_rr_d_gnt",  {31'd0, d1_d_gnt},  (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k % 2 == 0) push_if(32'h0000_0013, cyc + 2);
      else            push_d(32'h2222_2222, cyc + 2);
      step();
    end
    idle(4);
    active = 1'b0;

    // 6: fetch granted, reset asserted in the following cycle
    if_req  = 1'b1;
    if_addr = 32'h20;
    @(negedge clk);
    check("t6_if_gnt", {31'd0, d0_if_gnt}, 32'd1);
    step();
    if_req = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check("t6_rst_mem_en", {31'd0, d0_mem_en}, 32'd0);
    step();
    @(negedge clk);
    check("t6_no_if_rvalid", {31'd0, d0_if_rvalid}, 32'd0);
    check("t6_no_d_rvalid",  {31'd0, d0_d_rvalid},  32'd0);
    check("t6_if_rdata",     d0_if_rdata,           32'h0);
    check("t6_d_rdata",      d0_d_rdata,            32'h0);
    check("t6_gnts",         {30'd0, d0_if_gnt, d0_d_gnt}, 32'd0);
    step();
    reset = 1'b0;
    idle(4);
    check("queues_drained", exp_if.size() + exp_d.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
